// File: rtl/matmul_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl_if
//   Operand/result handshake bundle for the sequential matrix multiplier.
//   Matrices are row-major, element [0][0] in the MSBs:
//     M[r][c] = M[(N*N-1-(r*N+c))*DW +: DW]
//
//   Signals
//     in_valid   source -> block   A/B operands valid
//     in_ready   block  -> source  block can accept operands
//     A, B       source -> block   operand matrices (N*N*DW)
//     out_valid  block  -> sink    Result valid and held
//     out_ready  sink   -> block   sink accepts Result
//     Result     block  -> sink    product matrix (N*N*DW)
//     busy       block  -> any     job in progress (MAC or DONE)
//
//   Modports
//     master : operand source / result sink side
//     slave  : the multiplier
// -----------------------------------------------------------------------------
interface matmul_seq_ctrl_if #(
    parameter int N  = 3,
    parameter int DW = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [N*N*DW-1:0]   A;
    logic [N*N*DW-1:0]   B;
    logic                out_valid;
    logic                out_ready;
    logic [N*N*DW-1:0]   Result;
    logic                busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Result, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Result, busy
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
//   Sequential N x N unsigned matrix multiplier, Result = A x B, using a
//   single shared DW x DW multiply-accumulate unit. The FSM walks i/j/k and
//   performs one MAC per clock, so a job takes N*N*N cycles from the
//   accepting edge to out_valid.
//
//   Ports
//     clk   in   single clock, rising edge
//     rst   in   asynchronous, active-high reset (aborts any running job)
//     bus   slave modport of matmul_seq_ctrl_if
//             in_valid/in_ready  operand handshake (ready only in IDLE)
//             A, B               operand matrices, latched on accept
//             out_valid/out_ready result handshake, Result held until taken
//             Result             product matrix, elements written as produced
//             busy               high in MAC and DONE
//
//   Configuration macro
//     MATMUL_SAT_EN  defined   : each element saturates to 2^DW-1
//                    undefined : each element is the sum modulo 2^DW
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    matmul_seq_ctrl_if.slave bus
);

    localparam int NN = N * N;
    localparam int MW = NN * DW;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    // Full product plus log2(N) guard bits: one element's sum never overflows.
    localparam int AW = 2 * DW + IW;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_j;
    logic [IW-1:0]   r_k;
    logic [AW-1:0]   r_acc;
    logic [MW-1:0]   r_a;
    logic [MW-1:0]   r_b;
    logic [MW-1:0]   r_result;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic            w_accept;
    logic [DW-1:0]   w_a_elem;
    logic [DW-1:0]   w_b_elem;
    logic [2*DW-1:0] w_prod;
    logic [AW-1:0]   w_acc_next;
    logic [DW-1:0]   w_res_elem;

    // Flat bit offset of element [r][c] in the row-major, MSB-first packing.
    function automatic int elem_pos(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return (NN - 1 - (int'(r) * N + int'(c))) * DW;
    endfunction

    function automatic logic [DW-1:0] elem(input logic [MW-1:0] m,
                                           input logic [IW-1:0] r,
                                           input logic [IW-1:0] c);
        return m[elem_pos(r, c) +: DW];
    endfunction

`ifdef MATMUL_SAT_EN
    // Any bit set above the element width means the sum exceeds 2^DW-1.
    function automatic logic [DW-1:0] reduce_elem(input logic [AW-1:0] acc);
        return (|acc[AW-1:DW]) ? {DW{1'b1}} : acc[DW-1:0];
    endfunction
`else
    function automatic logic [DW-1:0] reduce_elem(input logic [AW-1:0] acc);
        return acc[DW-1:0];
    endfunction
`endif

    assign w_accept   = bus.in_valid && r_in_ready && (r_state == S_IDLE);

    assign w_a_elem   = elem(r_a, r_i, r_k);
    assign w_b_elem   = elem(r_b, r_k, r_j);
    assign w_prod     = {{DW{1'b0}}, w_a_elem} * {{DW{1'b0}}, w_b_elem};
    assign w_acc_next = r_acc + {{IW{1'b0}}, w_prod};
    assign w_res_elem = reduce_elem(w_acc_next);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.Result    = r_result;
    assign bus.busy      = r_busy;

    // Operand capture: data only, no reset needed. Later changes on A/B are
    // invisible to a running job.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.A;
            r_b <= bus.B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Comes up one cycle after reset release.
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_i        <= '0;
                        r_j        <= '0;
                        r_k        <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_MAC;
                    end
                end

                S_MAC: begin
                    if (r_k != LAST) begin
                        r_k   <= r_k + IW'(1);
                        r_acc <= w_acc_next;
                    end else begin
                        // Element complete: store it and move to the next (i, j).
                        r_result[elem_pos(r_i, r_j) +: DW] <= w_res_elem;
                        r_acc <= '0;
                        r_k   <= '0;
                        if (r_j != LAST) begin
                            r_j <= r_j + IW'(1);
                        end else begin
                            r_j <= '0;
                            if (r_i != LAST) begin
                                r_i <= r_i + IW'(1);
                            end else begin
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end
                        end
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
